// File: rtl/prog_sequencer.sv
// Program sequencer: generates the instruction-fetch address with linear step, jump,
// conditional relative branch and call/return through an internal return-address stack.
module prog_sequencer #(
    parameter int unsigned       ADDR_W      = 16,
    parameter logic [ADDR_W-1:0] RESET_VEC   = '0,
    parameter int unsigned       STACK_DEPTH = 8,
    parameter int unsigned       STEP        = 1,
    localparam int unsigned      DEPTH_W     = $clog2(STACK_DEPTH + 1)
) (
    input  logic               sys_clk,
    input  logic               reset_raw,
    input  logic               enable,
    input  logic [2:0]         op,
    input  logic [ADDR_W-1:0]  target,
    input  logic [ADDR_W-1:0]  offset,
    input  logic               cond,
    input  logic               clear_err,
    output logic [ADDR_W-1:0]  pc_out,
    output logic [DEPTH_W-1:0] depth,
    output logic               overflow,
    output logic               underflow
);

    localparam int unsigned       IDX_W  = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam logic [ADDR_W-1:0] STEP_V = ADDR_W'(STEP);
    localparam logic [DEPTH_W-1:0] FULL  = DEPTH_W'(STACK_DEPTH);

    localparam logic [2:0] OpNext   = 3'd0;
    localparam logic [2:0] OpJump   = 3'd1;
    localparam logic [2:0] OpBranch = 3'd2;
    localparam logic [2:0] OpCall   = 3'd3;
    localparam logic [2:0] OpRet    = 3'd4;

    if (STACK_DEPTH < 1) begin : g_bad_depth
        $error("prog_sequencer: STACK_DEPTH must be at least 1");
    end
    if (ADDR_W < 32 && STEP >= (32'd1 << ADDR_W)) begin : g_bad_step
        $error("prog_sequencer: STEP must be below 2**ADDR_W");
    end

    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [DEPTH_W-1:0] depth_q, depth_d;
    logic               overflow_q, overflow_d;
    logic               underflow_q, underflow_d;
    logic               push;
    logic               ovf_set, unf_set;
    logic [ADDR_W-1:0]  pc_step;
    logic [DEPTH_W-1:0] depth_m1;
    logic [IDX_W-1:0]   push_idx, pop_idx;
    logic [ADDR_W-1:0]  stack_q [STACK_DEPTH];

    assign pc_step  = pc_q + STEP_V;
    assign depth_m1 = depth_q - DEPTH_W'(1);
    assign push_idx = depth_q[IDX_W-1:0];
    assign pop_idx  = depth_m1[IDX_W-1:0];

    always_comb begin
        pc_d    = pc_q;
        depth_d = depth_q;
        push    = 1'b0;
        ovf_set = 1'b0;
        unf_set = 1'b0;
        if (enable) begin
            case (op)
                OpNext:   pc_d = pc_step;
                OpJump:   pc_d = target;
                OpBranch: pc_d = cond ? (pc_q + offset) : pc_step;
                OpCall: begin
                    if (depth_q != FULL) begin
                        push    = 1'b1;
                        depth_d = depth_q + DEPTH_W'(1);
                        pc_d    = target;
                    end else begin
                        // Call suppressed on a full stack; fall through as NEXT.
                        ovf_set = 1'b1;
                        pc_d    = pc_step;
                    end
                end
                OpRet: begin
                    if (depth_q != '0) begin
                        depth_d = depth_m1;
                        pc_d    = stack_q[pop_idx];
                    end else begin
                        unf_set = 1'b1;
                        pc_d    = pc_step;
                    end
                end
                default: ;
            endcase
        end
        // A new error wins over a same-cycle clear.
        overflow_d  = (overflow_q & ~clear_err) | ovf_set;
        underflow_d = (underflow_q & ~clear_err) | unf_set;
    end

    always_ff @(posedge sys_clk or negedge reset_raw) begin
        if (!reset_raw) begin
            pc_q        <= RESET_VEC;
            depth_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            pc_q        <= pc_d;
            depth_q     <= depth_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Stack storage needs no reset; only entries below depth are ever read.
    always_ff @(posedge sys_clk) begin
        if (push) begin
            stack_q[push_idx] <= pc_step;
        end
    end

    assign pc_out    = pc_q;
    assign depth     = depth_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

endmodule

// File: tb/tb_prog_sequencer.sv
// Directed self-checking bench for prog_sequencer (ADDR_W=16, STACK_DEPTH=2, STEP=1).
module tb_prog_sequencer;

    logic        sys_clk = 1'b0;
    logic        reset_raw;
    logic        enable;
    logic [2:0]  op;
    logic [15:0] target;
    logic [15:0] offset;
    logic        cond;
    logic        clear_err;
    logic [15:0] pc_out;
    logic [1:0]  depth;
    logic        overflow;
    logic        underflow;

    int checks = 0;
    int errors = 0;

    prog_sequencer #(
        .ADDR_W      (16),
        .RESET_VEC   (16'h0000),
        .STACK_DEPTH (2),
        .STEP        (1)
    ) dut (
        .sys_clk   (sys_clk),
        .reset_raw (reset_raw),
        .enable    (enable),
        .op        (op),
        .target    (target),
        .offset    (offset),
        .cond      (cond),
        .clear_err (clear_err),
        .pc_out    (pc_out),
        .depth     (depth),
        .overflow  (overflow),
        .underflow (underflow)
    );

    always #5 sys_clk = ~sys_clk;

    // Drive one op, let it be taken on the next rising edge, return 1 time unit after it.
    task automatic do_op(input logic [2:0] o, input logic [15:0] t, input logic [15:0] off,
                         input logic c, input logic clr);
        op        = o;
        target    = t;
        offset    = off;
        cond      = c;
        clear_err = clr;
        @(posedge sys_clk);
        #1;
        clear_err = 1'b0;
    endtask

    task automatic test_reset;
        logic [15:0] exp_pc;
        reset_raw = 1'b0;
        enable    = 1'b1;
        op        = 3'd0;
        repeat (2) @(posedge sys_clk);
        #1;
        checks++;
        if (pc_out !== 16'h0000 || depth !== 2'd0 || overflow !== 1'b0 || underflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_state pc=%h depth=%0d ovf=%b unf=%b required pc=0000 depth=0 flags=0",
                     pc_out, depth, overflow, underflow);
        end
        reset_raw = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            do_op(3'd0, 16'h0, 16'h0, 1'b0, 1'b0);
            exp_pc = 16'(i);
            checks++;
            if (pc_out !== exp_pc) begin
                errors++;
                $display("FAIL step_%0d pc=%h required %h", i, pc_out, exp_pc);
            end
        end
        #2 reset_raw = 1'b0;
        #1;
        checks++;
        if (pc_out !== 16'h0000) begin
            errors++;
            $display("FAIL async_reset_pc pc=%h required 0000", pc_out);
        end
        reset_raw = 1'b1;
    endtask

    task automatic test_wrap_hold;
        do_op(3'd1, 16'hFFFE, 16'h0, 1'b0, 1'b0);
        checks++;
        if (pc_out !== 16'hFFFE) begin
            errors++;
            $display("FAIL jump pc=%h required fffe", pc_out);
        end
        do_op(3'd0, 16'h0, 16'h0, 1'b0, 1'b0);
        checks++;
        if (pc_out !== 16'hFFFF) begin
            errors++;
            $display("FAIL next_top pc=%h required ffff", pc_out);
        end
        do_op(3'd0, 16'h0, 16'h0, 1'b0, 1'b0);
        checks++;
        if (pc_out !== 16'h0000) begin
            errors++;
            $display("FAIL wrap pc=%h required 0000", pc_out);
        end
        enable = 1'b0;
        for (int i = 0; i < 2; i++) begin
            do_op(3'd1, 16'h1234, 16'h0, 1'b0, 1'b0);
            checks++;
            if (pc_out !== 16'h0000) begin
                errors++;
                $display("FAIL enable_hold_%0d pc=%h required 0000", i, pc_out);
            end
        end
        enable = 1'b1;
    endtask

    task automatic test_branch;
        do_op(3'd1, 16'h0010, 16'h0, 1'b0, 1'b0);
        do_op(3'd2, 16'h0, 16'hFFF0, 1'b1, 1'b0);
        checks++;
        if (pc_out !== 16'h0000) begin
            errors++;
            $display("FAIL branch_back pc=%h required 0000", pc_out);
        end
        do_op(3'd1, 16'h0010, 16'h0, 1'b0, 1'b0);
        do_op(3'd2, 16'h0, 16'hFFF0, 1'b0, 1'b0);
        checks++;
        if (pc_out !== 16'h0011) begin
            errors++;
            $display("FAIL branch_not_taken pc=%h required 0011", pc_out);
        end
        do_op(3'd1, 16'hFFF0, 16'h0, 1'b0, 1'b0);
        do_op(3'd2, 16'h0, 16'h0020, 1'b1, 1'b0);
        checks++;
        if (pc_out !== 16'h0010) begin
            errors++;
            $display("FAIL branch_wrap pc=%h required 0010", pc_out);
        end
    endtask

    task automatic test_hold_reserved;
        do_op(3'd1, 16'h0ABC, 16'h0, 1'b0, 1'b0);
        for (int o = 5; o <= 7; o++) begin
            do_op(3'(o), 16'h5555, 16'h0001, 1'b1, 1'b0);
            checks++;
            if (pc_out !== 16'h0ABC || depth !== 2'd0) begin
                errors++;
                $display("FAIL hold_op%0d pc=%h depth=%0d required pc=0abc depth=0", o, pc_out, depth);
            end
        end
    endtask

    task automatic test_call_ret;
        logic [2:0]  ops   [4];
        logic [15:0] tgts  [4];
        logic [15:0] exp_p [4];
        logic [1:0]  exp_d [4];
        ops   = '{3'd3, 3'd3, 3'd4, 3'd4};
        tgts  = '{16'h0200, 16'h0300, 16'h0, 16'h0};
        exp_p = '{16'h0200, 16'h0300, 16'h0201, 16'h0101};
        exp_d = '{2'd1, 2'd2, 2'd1, 2'd0};
        do_op(3'd1, 16'h0100, 16'h0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            do_op(ops[i], tgts[i], 16'h0, 1'b0, 1'b0);
            checks++;
            if (pc_out !== exp_p[i] || depth !== exp_d[i]) begin
                errors++;
                $display("FAIL nest_%0d pc=%h depth=%0d required pc=%h depth=%0d",
                         i, pc_out, depth, exp_p[i], exp_d[i]);
            end
        end
        checks++;
        if (overflow !== 1'b0 || underflow !== 1'b0) begin
            errors++;
            $display("FAIL nest_flags ovf=%b unf=%b required 0 0", overflow, underflow);
        end
    endtask

    task automatic test_overflow_underflow;
        logic [2:0]  ops   [6];
        logic [15:0] exp_p [6];
        logic [1:0]  exp_d [6];
        logic        exp_o [6];
        logic        exp_u [6];
        ops   = '{3'd3, 3'd3, 3'd3, 3'd4, 3'd4, 3'd4};
        exp_p = '{16'h0400, 16'h0400, 16'h0401, 16'h0401, 16'h0001, 16'h0002};
        exp_d = '{2'd1, 2'd2, 2'd2, 2'd1, 2'd0, 2'd0};
        exp_o = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        exp_u = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        do_op(3'd1, 16'h0000, 16'h0, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            do_op(ops[i], 16'h0400, 16'h0, 1'b0, 1'b0);
            checks++;
            if (pc_out !== exp_p[i] || depth !== exp_d[i] || overflow !== exp_o[i] ||
                underflow !== exp_u[i]) begin
                errors++;
                $display("FAIL ovf_unf_%0d pc=%h d=%0d o=%b u=%b required pc=%h d=%0d o=%b u=%b",
                         i, pc_out, depth, overflow, underflow, exp_p[i], exp_d[i], exp_o[i],
                         exp_u[i]);
            end
        end
        do_op(3'd4, 16'h0, 16'h0, 1'b0, 1'b1);
        checks++;
        if (underflow !== 1'b1 || overflow !== 1'b0 || pc_out !== 16'h0003) begin
            errors++;
            $display("FAIL clear_vs_set u=%b o=%b pc=%h required u=1 o=0 pc=0003",
                     underflow, overflow, pc_out);
        end
        enable = 1'b0;
        do_op(3'd5, 16'h0, 16'h0, 1'b0, 1'b1);
        enable = 1'b1;
        checks++;
        if (underflow !== 1'b0 || overflow !== 1'b0 || pc_out !== 16'h0003) begin
            errors++;
            $display("FAIL clear_alone u=%b o=%b pc=%h required u=0 o=0 pc=0003",
                     underflow, overflow, pc_out);
        end
    endtask

    task automatic test_async_reset_stack;
        do_op(3'd3, 16'h0500, 16'h0, 1'b0, 1'b0);
        do_op(3'd3, 16'h0600, 16'h0, 1'b0, 1'b0);
        checks++;
        if (depth !== 2'd2 || pc_out !== 16'h0600) begin
            errors++;
            $display("FAIL pre_reset depth=%0d pc=%h required 2 0600", depth, pc_out);
        end
        #2 reset_raw = 1'b0;
        #1;
        checks++;
        if (depth !== 2'd0 || pc_out !== 16'h0000) begin
            errors++;
            $display("FAIL async_reset_stack depth=%0d pc=%h required 0 0000", depth, pc_out);
        end
        reset_raw = 1'b1;
        do_op(3'd4, 16'h0, 16'h0, 1'b0, 1'b0);
        checks++;
        if (underflow !== 1'b1 || pc_out !== 16'h0001) begin
            errors++;
            $display("FAIL ret_after_reset u=%b pc=%h required 1 0001", underflow, pc_out);
        end
    endtask

    initial begin
        reset_raw = 1'b0;
        enable    = 1'b0;
        op        = 3'd0;
        target    = '0;
        offset    = '0;
        cond      = 1'b0;
        clear_err = 1'b0;
        test_reset();
        test_wrap_hold();
        test_branch();
        test_hold_reserved();
        test_call_ret();
        test_overflow_underflow();
        test_async_reset_stack();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
